// File: rtl/f1_pkg.sv
// Shared definitions for the F1 start-light reaction timer.
// Provides the reaction FSM state type and the default saturation limit.
package f1_pkg;

    localparam int MAX_MS_DEFAULT = 9999;
    localparam int CNT_W_DEFAULT  = 14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_TIMING,
        ST_DONE,
        ST_FALSE_START
    } rt_state_t;

    // The driver-facing busy indicator covers waiting for lights-out and timing.
    function automatic logic is_busy(rt_state_t s);
        return (s == ST_ARMED) || (s == ST_TIMING);
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Brings the asynchronous driver button into the clk domain and turns its
// rising edge into a single-cycle press pulse, three clocks after the raw rise.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic sync3_q, sync3_d;
    logic pulse_q, pulse_d;

    // Next-state: two metastability flops, one history flop, registered edge.
    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        pulse_d = sync2_q & ~sync3_q;
    end

    // Register the synchronizer chain and the edge pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sync3_q <= sync3_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/reaction_timer.sv
// Reaction timer: arms on the light sequence start, times from lights-out to
// the driver's button press in 1 ms ticks, flags jump starts and saturates at
// MAX_MS. Define REACTION_BEST_EN to add best-time tracking on port best_ms.
module reaction_timer
    import f1_pkg::*;
#(
    parameter int MAX_MS = MAX_MS_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             arm,
    input  logic             go,
    input  logic             react,
    output logic [CNT_W-1:0] reaction_ms,
    output logic             valid,
    output logic             false_start,
    output logic             overflow,
`ifdef REACTION_BEST_EN
    output logic [CNT_W-1:0] best_ms,
`endif
    output logic             busy
);

    localparam logic [CNT_W-1:0] MAX_VAL  = CNT_W'(MAX_MS);
    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(MAX_MS - 1);

    logic press;

    edge_sync u_edge_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (react),
        .pulse (press)
    );

    rt_state_t        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] reaction_q, reaction_d;
    logic             valid_q, valid_d;
    logic             false_start_q, false_start_d;
    logic             overflow_q, overflow_d;
    logic             busy_q, busy_d;
    logic             arm_prev_q, arm_prev_d;
    logic             arm_rise;
`ifdef REACTION_BEST_EN
    logic [CNT_W-1:0] best_q, best_d;
`endif

    assign arm_rise = arm & ~arm_prev_q;

    // Next-state and output decode; an arm edge overrides everything else.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        reaction_d    = reaction_q;
        valid_d       = 1'b0;
        false_start_d = false_start_q;
        overflow_d    = overflow_q;
        arm_prev_d    = arm;
`ifdef REACTION_BEST_EN
        best_d        = best_q;
`endif
        if (arm_rise) begin
            state_d       = ST_ARMED;
            count_d       = '0;
            false_start_d = 1'b0;
            overflow_d    = 1'b0;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (press) begin
                        state_d       = ST_FALSE_START;
                        false_start_d = 1'b1;
                    end else if (go) begin
                        state_d = ST_TIMING;
                        count_d = '0;
                    end
                end
                ST_TIMING: begin
                    if (press) begin
                        state_d    = ST_DONE;
                        reaction_d = count_q;
                        valid_d    = 1'b1;
`ifdef REACTION_BEST_EN
                        if (count_q < best_q) begin
                            best_d = count_q;
                        end
`endif
                    end else if (tick) begin
                        if (count_q == LAST_VAL) begin
                            state_d    = ST_DONE;
                            reaction_d = MAX_VAL;
                            overflow_d = 1'b1;
                            valid_d    = 1'b1;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
        busy_d = is_busy(state_d);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            count_q       <= '0;
            reaction_q    <= '0;
            valid_q       <= 1'b0;
            false_start_q <= 1'b0;
            overflow_q    <= 1'b0;
            busy_q        <= 1'b0;
            arm_prev_q    <= 1'b0;
`ifdef REACTION_BEST_EN
            best_q        <= MAX_VAL;
`endif
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            reaction_q    <= reaction_d;
            valid_q       <= valid_d;
            false_start_q <= false_start_d;
            overflow_q    <= overflow_d;
            busy_q        <= busy_d;
            arm_prev_q    <= arm_prev_d;
`ifdef REACTION_BEST_EN
            best_q        <= best_d;
`endif
        end
    end

    assign reaction_ms = reaction_q;
    assign valid       = valid_q;
    assign false_start = false_start_q;
    assign overflow    = overflow_q;
    assign busy        = busy_q;
`ifdef REACTION_BEST_EN
    assign best_ms     = best_q;
`endif

endmodule
